// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampled UART receiver with 3-sample majority vote and false-start rejection.
// Define UART_RX_PARITY_EN to receive an even-parity bit between the payload and the stop bit.
module uart_rx_os16 #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned TICK_DIV  = CLK_FREQ / (BAUD * 16)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [TCW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [3:0]             s_cnt_q, s_cnt_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [2:0]             smp_q, smp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_done_q, rx_done_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   parity_err_q, parity_err_d;
`endif

    logic tick_c, mid_tick_c, end_tick_c;
    logic maj_live_c, maj_held_c;

    // Two-flop synchronizer; idles high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick_c     = (tick_cnt_q == TCW'(TICK_DIV - 1));
    assign mid_tick_c = tick_c && (s_cnt_q == 4'd9);
    assign end_tick_c = tick_c && (s_cnt_q == 4'd15);

    // Live vote completes on the s_cnt==9 tick; held vote uses samples 7/8/9 later in the bit.
    assign maj_live_c = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s_q) | (smp_q[0] & rx_s_q);
    assign maj_held_c = (smp_q[2] & smp_q[1]) | (smp_q[2] & smp_q[0]) | (smp_q[1] & smp_q[0]);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_c ? '0 : tick_cnt_q + TCW'(1);
        s_cnt_d     = tick_c ? s_cnt_q + 4'd1 : s_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        smp_d       = (tick_c && (s_cnt_q >= 4'd7) && (s_cnt_q <= 4'd9)) ?
                      {smp_q[1:0], rx_s_q} : smp_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = parity_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Hold the divider at zero so ticks are phase-aligned to the start edge.
                tick_cnt_d = '0;
                s_cnt_d    = 4'd0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Start is validated mid-bit; data cells begin at the start bit's end.
                if (mid_tick_c && maj_live_c) begin
                    state_d = S_IDLE;
                end else if (end_tick_c) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (end_tick_c) begin
                    shift_d = {maj_held_c, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (end_tick_c) begin
                    par_bad_d = maj_held_c ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Deliver mid-stop-bit so a following start edge is never missed.
                if (mid_tick_c) begin
                    rx_data_d   = shift_q;
                    rx_done_d   = 1'b1;
                    frame_err_d = ~maj_live_c;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad_q;
`endif
                    state_d     = maj_live_c ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            s_cnt_q     <= 4'd0;
            bit_cnt_q   <= '0;
            smp_q       <= 3'd0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            s_cnt_q     <= s_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            smp_q       <= smp_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16 at a scaled clock (160 clk/bit): expected frames are queued as they are
// driven and popped against what the DUT presents on each rx_done pulse.
module tb_uart_rx_os16;

    localparam int unsigned CLK_FREQ    = 1_600_000;
    localparam int unsigned BAUD        = 10_000;
    localparam int unsigned DW          = 8;
    localparam int          CLK_PER_BIT = 160;
    localparam int          BIT_T       = 1600;
    localparam int          BUDGET      = 14 * CLK_PER_BIT;
`ifdef UART_RX_PARITY_EN
    localparam int          FRAME_BITS  = 11;
`else
    localparam int          FRAME_BITS  = 10;
`endif
    // Start edge to rx_done: (frame bits - 1) bits, 10 ticks into stop, plus synchronizer/entry clocks.
    localparam int          LAT_NOM     = (FRAME_BITS - 1) * CLK_PER_BIT + 100 + 3;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct packed {
        logic [7:0]  data;
        logic        ferr;
        logic        perr;
        logic        busy;
        logic [31:0] cyc;
    } cap_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_done;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    logic [31:0]   cyc = '0;
    logic [31:0]   start_cyc = '0;
    logic          prev_done = 1'b0;
    int            done_cnt = 0;
    int            wide_cnt = 0;
    int            vectors = 0;
    int            miscompares = 0;
    exp_t          exp_q[$];
    cap_t          cap_q[$];
`ifdef UART_RX_PARITY_EN
    logic          par_flip = 1'b0;
`endif

    uart_rx_os16 #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .DATA_BITS (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture what the DUT presents on every rx_done; also track pulse width.
    always @(negedge clk) begin
        prev_done <= rx_done;
        if (rx_done === 1'b1) begin
            cap_q.push_back({rx_data, frame_err, parity_err, busy, cyc});
            done_cnt <= done_cnt + 1;
            if (prev_done === 1'b1) wide_cnt <= wide_cnt + 1;
        end
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "watchdog timeout");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_t);
        start_cyc = cyc;
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < int'(DW); i++) begin
            rx = d[i];
            #(bit_t);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        #(bit_t);
`endif
        rx = stop_bit;
        #(bit_t);
    endtask

    task automatic wait_cap(input int max_clk, output bit got, output cap_t c);
        got = 1'b0;
        c   = '0;
        for (int i = 0; i < max_clk && cap_q.size() == 0; i++) @(negedge clk);
        if (cap_q.size() != 0) begin
            c   = cap_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (rx_data !== 8'h00) begin $display("FAIL reset_rx_data: got %02h, expected 00", rx_data); miscompares++; end
        vectors++; if (rx_done !== 1'b0) begin $display("FAIL reset_rx_done: got %b, expected 0", rx_done); miscompares++; end
        vectors++; if (frame_err !== 1'b0) begin $display("FAIL reset_frame_err: got %b, expected 0", frame_err); miscompares++; end
        vectors++; if (parity_err !== 1'b0) begin $display("FAIL reset_parity_err: got %b, expected 0", parity_err); miscompares++; end
        vectors++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b, expected 0", busy); miscompares++; end
        rst = 1'b1;
        repeat (20) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin $display("FAIL reset_idle_busy: got %b, expected 0", busy); miscompares++; end
    endtask

    task automatic test_nominal();
        exp_t e; cap_t c; bit got; int d0; logic [31:0] lat;
        d0 = done_cnt;
        exp_q.push_back({8'h55, 1'b0, 1'b0});
        @(negedge clk);
        send_frame(8'h55, 1'b1, BIT_T);
        wait_cap(BUDGET, got, c);
        e = exp_q.pop_front();
        vectors++;
        if (!got) begin
            $display("FAIL nominal_done: no rx_done within budget, expected data=%02h", e.data); miscompares++;
        end else begin
            vectors++;
            if ({c.data, c.ferr, c.perr} !== e) begin
                $display("FAIL nominal_frame: got data=%02h ferr=%b perr=%b, expected data=%02h ferr=%b perr=%b",
                         c.data, c.ferr, c.perr, e.data, e.ferr, e.perr); miscompares++;
            end
            lat = c.cyc - start_cyc;
            vectors++;
            if (lat < 32'(LAT_NOM - 8) || lat > 32'(LAT_NOM + 8)) begin
                $display("FAIL nominal_latency: got %0d clk, expected %0d +/- 8", lat, LAT_NOM); miscompares++;
            end
            vectors++;
            if (c.busy !== 1'b0) begin $display("FAIL nominal_busy_at_done: got %b, expected 0", c.busy); miscompares++; end
        end
        repeat (CLK_PER_BIT) @(negedge clk);
        vectors++;
        if (done_cnt - d0 !== 1) begin $display("FAIL nominal_pulse_count: got %0d, expected 1", done_cnt - d0); miscompares++; end
    endtask

    task automatic test_back_to_back();
        exp_t e; cap_t c; bit got; int d0;
        d0 = done_cnt;
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        exp_q.push_back({8'hFF, 1'b0, 1'b0});
        @(negedge clk);
        send_frame(8'h00, 1'b1, BIT_T);
        send_frame(8'hFF, 1'b1, BIT_T);
        for (int k = 0; k < 2; k++) begin
            wait_cap(BUDGET, got, c);
            e = exp_q.pop_front();
            vectors++;
            if (!got) begin
                $display("FAIL b2b_done%0d: no rx_done within budget, expected data=%02h", k, e.data); miscompares++;
            end else if ({c.data, c.ferr, c.perr} !== e) begin
                $display("FAIL b2b_frame%0d: got data=%02h ferr=%b perr=%b, expected data=%02h ferr=%b perr=%b",
                         k, c.data, c.ferr, c.perr, e.data, e.ferr, e.perr); miscompares++;
            end
        end
        vectors++;
        if (done_cnt - d0 !== 2) begin $display("FAIL b2b_pulse_count: got %0d, expected 2", done_cnt - d0); miscompares++; end
    endtask

    task automatic test_glitch();
        exp_t e; cap_t c; bit got; int d0;
        d0 = done_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin $display("FAIL glitch_busy_high: got %b, expected 1", busy); miscompares++; end
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (90) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin $display("FAIL glitch_busy_released: got %b, expected 0", busy); miscompares++; end
        repeat (2 * CLK_PER_BIT) @(negedge clk);
        vectors++; if (done_cnt !== d0) begin $display("FAIL glitch_no_done: got %0d pulses, expected 0", done_cnt - d0); miscompares++; end
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 1'b1, BIT_T);
        wait_cap(BUDGET, got, c);
        e = exp_q.pop_front();
        vectors++;
        if (!got) begin
            $display("FAIL glitch_after_done: no rx_done within budget, expected data=%02h", e.data); miscompares++;
        end else if ({c.data, c.ferr, c.perr} !== e) begin
            $display("FAIL glitch_after_frame: got data=%02h ferr=%b perr=%b, expected data=%02h ferr=%b perr=%b",
                     c.data, c.ferr, c.perr, e.data, e.ferr, e.perr); miscompares++;
        end
    endtask

    task automatic test_framing();
        exp_t e; cap_t c; bit got; int d0;
        d0 = done_cnt;
        exp_q.push_back({8'hA3, 1'b1, 1'b0});
        @(negedge clk);
        send_frame(8'hA3, 1'b0, BIT_T);
        #(3 * BIT_T);
        wait_cap(BUDGET, got, c);
        e = exp_q.pop_front();
        vectors++;
        if (!got) begin
            $display("FAIL framing_done: no rx_done within budget, expected data=%02h", e.data); miscompares++;
        end else if ({c.data, c.ferr, c.perr} !== e) begin
            $display("FAIL framing_frame: got data=%02h ferr=%b perr=%b, expected data=%02h ferr=%b perr=%b",
                     c.data, c.ferr, c.perr, e.data, e.ferr, e.perr); miscompares++;
        end
        vectors++; if (done_cnt - d0 !== 1) begin $display("FAIL framing_single_done: got %0d, expected 1", done_cnt - d0); miscompares++; end
        vectors++; if (busy !== 1'b1) begin $display("FAIL framing_busy_low_line: got %b, expected 1", busy); miscompares++; end
        rx = 1'b1;
        #(BIT_T);
        vectors++; if (busy !== 1'b0) begin $display("FAIL framing_busy_after_high: got %b, expected 0", busy); miscompares++; end
        exp_q.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(8'h3C, 1'b1, BIT_T);
        wait_cap(BUDGET, got, c);
        e = exp_q.pop_front();
        vectors++;
        if (!got) begin
            $display("FAIL framing_recover_done: no rx_done within budget, expected data=%02h", e.data); miscompares++;
        end else if ({c.data, c.ferr, c.perr} !== e) begin
            $display("FAIL framing_recover_frame: got data=%02h ferr=%b perr=%b, expected data=%02h ferr=%b perr=%b",
                     c.data, c.ferr, c.perr, e.data, e.ferr, e.perr); miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; cap_t c; bit got; int d0; logic [7:0] v;
        v  = 8'h96;
        d0 = done_cnt;
        @(negedge clk);
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            rx = v[i];
            #(BIT_T);
        end
        rx = v[4];
        #(BIT_T / 2);
        vectors++; if (busy !== 1'b1) begin $display("FAIL rstmid_busy_before: got %b, expected 1", busy); miscompares++; end
        rst = 1'b0;
        #1;
        vectors++;
        if ({rx_data, rx_done, frame_err, parity_err, busy} !== 12'h000) begin
            $display("FAIL rstmid_outputs: got data=%02h done=%b ferr=%b perr=%b busy=%b, expected all 0",
                     rx_data, rx_done, frame_err, parity_err, busy); miscompares++;
        end
        rx = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        repeat (12 * CLK_PER_BIT) @(negedge clk);
        vectors++; if (done_cnt !== d0) begin $display("FAIL rstmid_no_done: got %0d pulses, expected 0", done_cnt - d0); miscompares++; end
        exp_q.push_back({8'h96, 1'b0, 1'b0});
        send_frame(8'h96, 1'b1, BIT_T);
        wait_cap(BUDGET, got, c);
        e = exp_q.pop_front();
        vectors++;
        if (!got) begin
            $display("FAIL rstmid_after_done: no rx_done within budget, expected data=%02h", e.data); miscompares++;
        end else if ({c.data, c.ferr, c.perr} !== e) begin
            $display("FAIL rstmid_after_frame: got data=%02h ferr=%b perr=%b, expected data=%02h ferr=%b perr=%b",
                     c.data, c.ferr, c.perr, e.data, e.ferr, e.perr); miscompares++;
        end
    endtask

    task automatic test_baud_skew();
        exp_t e; cap_t c; bit got;
        int bt[2];
        bt[0] = 1569;   // +2% baud
        bt[1] = 1632;   // -2% baud
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({8'h7E, 1'b0, 1'b0});
            @(negedge clk);
            send_frame(8'h7E, 1'b1, bt[k]);
            #(BIT_T);
            wait_cap(BUDGET, got, c);
            e = exp_q.pop_front();
            vectors++;
            if (!got) begin
                $display("FAIL skew_done%0d: no rx_done within budget, expected data=%02h", k, e.data); miscompares++;
            end else if ({c.data, c.ferr, c.perr} !== e) begin
                $display("FAIL skew_frame%0d: got data=%02h ferr=%b perr=%b, expected data=%02h ferr=%b perr=%b",
                         k, c.data, c.ferr, c.perr, e.data, e.ferr, e.perr); miscompares++;
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        exp_t e; cap_t c; bit got;
        for (int k = 0; k < 2; k++) begin
            par_flip = (k == 0);
            exp_q.push_back({8'h01, 1'b0, par_flip});
            @(negedge clk);
            send_frame(8'h01, 1'b1, BIT_T);
            wait_cap(BUDGET, got, c);
            e = exp_q.pop_front();
            vectors++;
            if (!got) begin
                $display("FAIL parity_done%0d: no rx_done within budget, expected data=%02h", k, e.data); miscompares++;
            end else if ({c.data, c.ferr, c.perr} !== e) begin
                $display("FAIL parity_frame%0d: got data=%02h ferr=%b perr=%b, expected data=%02h ferr=%b perr=%b",
                         k, c.data, c.ferr, c.perr, e.data, e.ferr, e.perr); miscompares++;
            end
        end
        par_flip = 1'b0;
    endtask
`endif

    task automatic test_wrapup();
        repeat (2 * CLK_PER_BIT) @(negedge clk);
        vectors++; if (wide_cnt !== 0) begin $display("FAIL done_pulse_width: got %0d wide pulses, expected 0", wide_cnt); miscompares++; end
        vectors++; if (cap_q.size() !== 0) begin $display("FAIL unexpected_done: got %0d extra captures, expected 0", cap_q.size()); miscompares++; end
        vectors++; if (exp_q.size() !== 0) begin $display("FAIL missing_done: got %0d unmatched frames, expected 0", exp_q.size()); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
        test_baud_skew();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_wrapup();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
